// File: rtl/div_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest multiple of size_cs that holds n+1 bits (room for the shifted-in bit).
  function automatic int calc_w(input int n, input int size_cs);
    return ((n + size_cs) / size_cs) * size_cs;
  endfunction

endpackage

// File: rtl/cs_subtractor.sv
// Carry-select subtractor: diff = a - b computed as a + ~b + 1.
// Each stage runs two ripple adders (carry-in 0 and 1) and picks one on the incoming carry.
module cs_stage #(
  parameter int SIZE_CS = 4
) (
  input  logic [SIZE_CS-1:0] a,
  input  logic [SIZE_CS-1:0] b,
  input  logic               cin,
  output logic [SIZE_CS-1:0] sum,
  output logic               cout
);

  logic [SIZE_CS-1:0] s0, s1;
  logic [SIZE_CS:0]   c0, c1;

  always_comb begin
    s0    = '0;
    s1    = '0;
    c0    = '0;
    c1    = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < SIZE_CS; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1[SIZE_CS] : c0[SIZE_CS];

endmodule

module cs_subtractor #(
  parameter int W       = 20,
  parameter int SIZE_CS = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         cout
);

  localparam int NS = W / SIZE_CS;

  logic [W-1:0] b_n;
  logic         carry [0:NS];

  assign b_n      = ~b;
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NS; g++) begin : g_stage
    cs_stage #(.SIZE_CS(SIZE_CS)) u_stage (
      .a   (a[g*SIZE_CS +: SIZE_CS]),
      .b   (b_n[g*SIZE_CS +: SIZE_CS]),
      .cin (carry[g]),
      .sum (diff[g*SIZE_CS +: SIZE_CS]),
      .cout(carry[g+1])
    );
  end

  // Final carry of 1 means no borrow, i.e. a >= b.
  assign cout = carry[NS];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Start/ready handshake in, single-cycle valid strobe with held results out.
module seq_divider
  import div_pkg::*;
#(
  parameter int N       = 16,
  parameter int SIZE_CS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         div_by_zero_o
);

  localparam int W  = calc_w(N, SIZE_CS);
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
  } rsp_t;

  state_t       state, state_nxt;
  logic [W-1:0] r_q;
  logic [N-1:0] q_q, d_q;
  logic [CW-1:0] cnt;
  rsp_t         rsp_q;

  logic [W-1:0] r_sh, t_diff, r_nxt;
  logic [N-1:0] q_nxt;
  logic         t_cout, accept, last_step, div_zero_req;

  assign accept       = (state == IDLE) && start_i;
  assign div_zero_req = (divisor_i == '0);
  assign last_step    = (cnt == CW'(N - 1));

  // Shift the next dividend bit into the partial remainder, then trial-subtract D.
  assign r_sh = W'({r_q, q_q[N-1]});

  cs_subtractor #(.W(W), .SIZE_CS(SIZE_CS)) u_sub (
    .a   (r_sh),
    .b   ({{(W-N){1'b0}}, d_q}),
    .diff(t_diff),
    .cout(t_cout)
  );

  assign r_nxt = t_cout ? t_diff : r_sh;
  assign q_nxt = {q_q[N-2:0], t_cout};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = div_zero_req ? DONE : CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt   <= '0;
      rsp_q <= '0;
    end else if (accept) begin
      q_q               <= dividend_i;
      d_q               <= divisor_i;
      r_q               <= '0;
      cnt               <= '0;
      rsp_q.div_by_zero <= div_zero_req;
      // Divide-by-zero resolves immediately; normal results wait for the last step.
      if (div_zero_req) begin
        rsp_q.quotient  <= '1;
        rsp_q.remainder <= dividend_i;
      end
    end else if (state == CALC) begin
      r_q <= r_nxt;
      q_q <= q_nxt;
      cnt <= cnt + CW'(1);
      if (last_step) begin
        rsp_q.quotient  <= q_nxt;
        rsp_q.remainder <= r_nxt[N-1:0];
      end
    end
  end

  assign quotient_o    = rsp_q.quotient;
  assign remainder_o   = rsp_q.remainder;
  assign div_by_zero_o = rsp_q.div_by_zero;

endmodule
